// File: rtl/hazard_sched_ctrl_pkg.sv
// hazard_sched_ctrl_pkg
// Shared definitions for the RV32 pipeline scheduler. The datapath forwarding
// muxes and the control decoder use these encodings too.
//   sched_state_t : scheduler FSM state encoding
//   FWD_*         : EX-stage forwarding mux selects
//   RESULT_LOAD   : ResultSrc encoding of a load
//   fwd_hit()     : true when a writing stage produces the register being read
package hazard_sched_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } sched_state_t;

    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_MEM     = 2'b10;
    localparam logic [1:0] FWD_WB      = 2'b01;
    localparam logic [1:0] RESULT_LOAD = 2'b01;

    // x0 is hard-wired to zero, so a write to it never forwards.
    function automatic logic fwd_hit(input logic       we,
                                     input logic [4:0] rd,
                                     input logic [4:0] rs);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_sched_ctrl_fwd_unit.sv
// hazard_sched_ctrl_fwd_unit
// Combinational EX-stage forwarding selects. The MEM-stage result is newer
// than the WB-stage result, so it wins when both match.
// Ports:
//   rs1_EX, rs2_EX             : source registers of the instruction in EX
//   rd_MEM, RegWrite_MEM       : destination / write enable in MEM
//   rd_WB, RegWrite_WB         : destination / write enable in WB
//   ForwardA, ForwardB         : mux selects (FWD_RF / FWD_MEM / FWD_WB)
module hazard_sched_ctrl_fwd_unit
    import hazard_sched_ctrl_pkg::*;
(
    input  logic [4:0] rs1_EX,
    input  logic [4:0] rs2_EX,
    input  logic [4:0] rd_MEM,
    input  logic       RegWrite_MEM,
    input  logic [4:0] rd_WB,
    input  logic       RegWrite_WB,
    output logic [1:0] ForwardA,
    output logic [1:0] ForwardB
);

    always_comb begin
        ForwardA = FWD_RF;
        if (fwd_hit(RegWrite_MEM, rd_MEM, rs1_EX))
            ForwardA = FWD_MEM;
        else if (fwd_hit(RegWrite_WB, rd_WB, rs1_EX))
            ForwardA = FWD_WB;

        ForwardB = FWD_RF;
        if (fwd_hit(RegWrite_MEM, rd_MEM, rs2_EX))
            ForwardB = FWD_MEM;
        else if (fwd_hit(RegWrite_WB, rd_WB, rs2_EX))
            ForwardB = FWD_WB;
    end

endmodule

// File: rtl/hazard_sched_ctrl.sv
// hazard_sched_ctrl
// Pipeline scheduler for the 5-stage RV32 core: per-stage stall/flush enables,
// EX forwarding selects and an FSM covering data-memory wait states and
// branch flushes deferred across a memory wait.
// Parameters: MEM_TIMEOUT (wait cycles before err_timeout), CNT_W (perf counter width)
// Ports:
//   clk, rst (synchronous, active-high)
//   ID/EX/MEM/WB register ids and write enables, ResultSrc_EX, PCSrc_MEM
//   dmem_req, dmem_ready      : MEM stage memory handshake
//   stall_*, flush_*          : pipeline register hold / bubble enables
//   ForwardA, ForwardB        : EX forwarding selects
//   err_timeout               : one-cycle pulse on a too-long memory wait
//   busy                      : FSM is not in RUN
// Optional feature: define HAZ_PERF_CNT_EN to add stall_cnt, flush_cnt and
// lu_cnt saturating performance counters.
//
// State table:
//   RUN      | normal issue; resolves memory wait, branch flush, load-use
//   MEM_WAIT | data memory not ready; whole pipe held, MEM_WB bubbled
//   FLUSH    | flush of a branch that resolved while memory was waiting
module hazard_sched_ctrl
    import hazard_sched_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic [4:0]       rs1_EX,
    input  logic [4:0]       rs2_EX,
    input  logic [4:0]       rd_EX,
    input  logic             RegWrite_EX,
    input  logic [1:0]       ResultSrc_EX,
    input  logic [4:0]       rd_MEM,
    input  logic             RegWrite_MEM,
    input  logic [4:0]       rd_WB,
    input  logic             RegWrite_WB,
    input  logic             PCSrc_MEM,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             stall_PC,
    output logic             stall_IF_ID,
    output logic             stall_ID_EX,
    output logic             stall_EX_MEM,
    output logic             flush_IF_ID,
    output logic             flush_ID_EX,
    output logic             flush_EX_MEM,
    output logic             flush_MEM_WB,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic             err_timeout,
    output logic             busy
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] lu_cnt
`endif
);

    localparam int                WCNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_TIMEOUT - 1);
    localparam logic [WCNT_W-1:0] WAIT_SAT  = WCNT_W'(MEM_TIMEOUT);

    sched_state_t      state;
    logic              pend_flush;
    logic [WCNT_W-1:0] wait_cnt;
    logic              lu;
    logic              mem_block;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;

    hazard_sched_ctrl_fwd_unit u_fwd (
        .rs1_EX       (rs1_EX),
        .rs2_EX       (rs2_EX),
        .rd_MEM       (rd_MEM),
        .RegWrite_MEM (RegWrite_MEM),
        .rd_WB        (rd_WB),
        .RegWrite_WB  (RegWrite_WB),
        .ForwardA     (fwd_a),
        .ForwardB     (fwd_b)
    );

    assign lu = RegWrite_EX && (ResultSrc_EX == RESULT_LOAD) && (rd_EX != 5'd0) &&
                ((rd_EX == rs1_ID) || (rd_EX == rs2_ID));
    assign mem_block = dmem_req && !dmem_ready;

    // Enables must act in the same cycle the hazard is seen, so they are
    // decoded from the registered state plus current inputs. Everything is
    // forced low while rst is held.
    always_comb begin
        stall_PC     = 1'b0;
        stall_IF_ID  = 1'b0;
        stall_ID_EX  = 1'b0;
        stall_EX_MEM = 1'b0;
        flush_IF_ID  = 1'b0;
        flush_ID_EX  = 1'b0;
        flush_EX_MEM = 1'b0;
        flush_MEM_WB = 1'b0;
        err_timeout  = 1'b0;
        if (!rst) begin
            unique case (state)
                RUN: begin
                    if (mem_block) begin
                        {stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM} = 4'hF;
                        flush_MEM_WB = 1'b1;
                    end else if (PCSrc_MEM) begin
                        {flush_IF_ID, flush_ID_EX, flush_EX_MEM} = 3'b111;
                    end else if (lu) begin
                        stall_PC    = 1'b1;
                        stall_IF_ID = 1'b1;
                        flush_ID_EX = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    // The ready cycle releases the pipe so MEM can retire.
                    if (!dmem_ready) begin
                        {stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM} = 4'hF;
                        flush_MEM_WB = 1'b1;
                    end
                    // wait_cnt saturates above WAIT_LAST, so this fires once.
                    err_timeout = (wait_cnt == WAIT_LAST);
                end
                FLUSH: begin
                    {flush_IF_ID, flush_ID_EX, flush_EX_MEM} = 3'b111;
                end
                default: ;
            endcase
        end
    end

    assign ForwardA = rst ? FWD_RF : fwd_a;
    assign ForwardB = rst ? FWD_RF : fwd_b;
    assign busy     = !rst && (state != RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            pend_flush <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (mem_block) begin
                        state      <= MEM_WAIT;
                        pend_flush <= PCSrc_MEM;
                        wait_cnt   <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        state    <= pend_flush ? FLUSH : RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt != WAIT_SAT) begin
                        wait_cnt <= wait_cnt + WCNT_W'(1);
                    end
                end
                FLUSH: begin
                    pend_flush <= 1'b0;
                    state      <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic any_stall;
    logic any_flush;

    assign any_stall = stall_PC | stall_IF_ID | stall_ID_EX | stall_EX_MEM;
    assign any_flush = flush_IF_ID | flush_ID_EX | flush_EX_MEM | flush_MEM_WB;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            lu_cnt    <= '0;
        end else begin
            if (any_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (any_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
            if (lu && (lu_cnt != '1))           lu_cnt    <= lu_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: doc/hazard_sched_ctrl.md
Name: hazard_sched_ctrl

Overview:
- Pipeline scheduler for the 5-stage RV32 core; sequences the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers.
- Produces per-stage stall (hold) and flush (bubble) enables.
- Produces EX-stage forwarding selects.
- Runs an FSM for data-memory wait states and deferred branch flushes. Taken branches resolve in MEM from the EX_MEM outputs.

Parameters:
- MEM_TIMEOUT, 16: max consecutive dmem wait cycles before the err_timeout pulse.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- rs1_ID, rs2_ID  in  5 each  source registers of the instruction in ID.
- rs1_EX, rs2_EX  in  5 each  source registers in EX.
- rd_EX  in  5  destination in EX.
- RegWrite_EX  in  1  register write enable in EX.
- ResultSrc_EX  in  2  2'b01 = load.
- rd_MEM, RegWrite_MEM  in  5/1  destination and write enable in MEM.
- rd_WB, RegWrite_WB  in  5/1  destination and write enable in WB.
- PCSrc_MEM  in  1  taken branch/jump resolved in MEM.
- dmem_req  in  1  MEM stage accesses memory (Mem_Con_MEM != 0).
- dmem_ready  in  1  memory completes the access this cycle.
- stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM  out  1 each  hold register contents.
- flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB  out  1 each  load zeros (bubble).
- ForwardA, ForwardB  out  2 each  00 = regfile, 10 = MEM ALUresult, 01 = WB result.
- err_timeout  out  1  one-cycle pulse.
- busy  out  1  FSM not in RUN.

Behaviour:
- Reset: every output is 0; state is RUN; pend_flush, wait_cnt and the counters are 0.
- Forwarding (combinational, zero latency):
  - ForwardA = 10 if RegWrite_MEM && rd_MEM != 0 && rd_MEM == rs1_EX.
  - Otherwise 01 if RegWrite_WB && rd_WB != 0 && rd_WB == rs1_EX.
  - Otherwise 00. MEM has priority over WB. ForwardB is the same using rs2_EX.
- Load-use detection: lu = RegWrite_EX && ResultSrc_EX == 01 && rd_EX != 0 && (rd_EX == rs1_ID || rd_EX == rs2_ID).
- State RUN:
  - dmem_req && !dmem_ready: enter MEM_WAIT next cycle, and this cycle assert stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM and flush_MEM_WB. If PCSrc_MEM is also high, set pend_flush.
  - Else if PCSrc_MEM: assert flush_IF_ID, flush_ID_EX and flush_EX_MEM for this single cycle; stay in RUN.
  - Else if lu: assert stall_PC, stall_IF_ID and flush_ID_EX for one cycle.
  - Priority order: memory wait > branch flush > load-use.
- State MEM_WAIT:
  - Assert the same stalls plus flush_MEM_WB.
  - wait_cnt increments each cycle.
  - On dmem_ready, go to RUN, or to FLUSH if pend_flush is set. Clear wait_cnt.
  - When wait_cnt reaches MEM_TIMEOUT-1, pulse err_timeout once; stay in MEM_WAIT.
- State FLUSH:
  - Assert flush_IF_ID, flush_ID_EX and flush_EX_MEM for exactly one cycle.
  - Clear pend_flush and return to RUN.
  - PCSrc_MEM is ignored in this state; the instruction in MEM is the flushed one.
- busy = 1 in MEM_WAIT and FLUSH.
- A stall and a flush of the same register are never both asserted.
- Mid-operation reset clears the state and pend_flush in the next cycle, with no residual stalls.
- wait_cnt saturates at MEM_TIMEOUT; it does not wrap.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined: adds output ports stall_cnt, flush_cnt and lu_cnt, each CNT_W bits.
  - Each counter increments once per cycle in which any stall, any flush, or lu (respectively) is asserted.
  - Counters saturate at all-ones and reset to 0.
- Undefined: no ports and no counter logic.

Decomposition:
- Shared package: FSM state encoding (RUN=2'd0, MEM_WAIT=2'd1, FLUSH=2'd2), Forward select constants (FWD_RF, FWD_MEM, FWD_WB) and RESULT_LOAD=2'b01.
- These constants are shared with the datapath muxes and the control decoder.
- One natural sub-module: fwd_unit, the combinational forwarding logic, reused by the verification model.

Test Plan:
- Load-use: lw x5 in EX (rd_EX=5, ResultSrc_EX=01); ID uses rs1_ID=5 -> one cycle of stall_PC=stall_IF_ID=flush_ID_EX=1, then all 0.
- Forwarding: RegWrite_MEM=1, rd_MEM=3, RegWrite_WB=1, rd_WB=3, rs1_EX=3 -> ForwardA=10. Same with rd_MEM=0 -> ForwardA=01.
- Branch: PCSrc_MEM=1 in RUN -> flush_IF_ID, flush_ID_EX and flush_EX_MEM high for 1 cycle; busy stays 0.
- Memory wait with deferred branch: dmem_req=1, dmem_ready=0 for 3 cycles with PCSrc_MEM=1 on the first -> stalls for 3 cycles. After ready: 1 FLUSH cycle, then RUN.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 -> err_timeout pulses once at the 4th wait cycle; stalls persist.
- Reset in MEM_WAIT: rst=1 for 1 cycle -> all outputs 0 the next cycle; state RUN; pend_flush cleared.
